// File: rtl/adc_sample_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sample_sched_if
//  Description : Handshake between the sample scheduler (master) and the
//                SPI ADC engine (slave): start request, busy, result strobe
//                and data.
//  Revision    : 1.0 - initial release
// ============================================================================
interface adc_sample_sched_if;
    logic        adc_start;
    logic        adc_busy;
    logic        adc_valid;
    logic [11:0] adc_data;

    modport master (
        output adc_start,
        input  adc_busy,
        input  adc_valid,
        input  adc_data
    );

    modport slave (
        input  adc_start,
        output adc_busy,
        output adc_valid,
        output adc_data
    );
endinterface
`default_nettype wire

// File: rtl/adc_sample_sched.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sample_sched
//  Description : Periodically requests ADC conversions, averages batches of
//                2**AVG_LOG2 samples, converts the average to four BCD
//                digits by serial double-dabble and publishes them. Sticky
//                overrun and timeout flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_sample_sched #(
    parameter int PERIOD_W = 24,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    input  logic                err_clr,
    adc_sample_sched_if.master  adc,
    output logic [3:0]          ones,
    output logic [3:0]          tens,
    output logic [3:0]          hundreds,
    output logic [3:0]          thousands,
    output logic                disp_valid,
    output logic                overrun,
    output logic                timeout_err
);

    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [TO_W-1:0]  c_to_last  = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TICK = 3'd1,
        S_START     = 3'd2,
        S_WAIT_DATA = 3'd3,
        S_LOAD      = 3'd4,
        S_BCD       = 3'd5,
        S_PUBLISH   = 3'd6
    } state_t;

    state_t              r_state;
    logic [PERIOD_W-1:0] r_tick_cnt;
    logic [PERIOD_W-1:0] r_period;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [TO_W-1:0]     r_to_cnt;
    logic [11:0]         r_bin;
    logic [15:0]         r_bcd;
    logic [3:0]          r_iter;
    logic [15:0]         r_digits;
    logic                r_adc_start;
    logic                r_disp_valid;
    logic                r_overrun;
    logic                r_timeout;

    logic [PERIOD_W-1:0] w_period_sat;
    logic                w_tick;
    logic                w_ovr_set;
    logic                w_to_set;
    logic [15:0]         w_bcd_adj;

    // Periods below 2 would make the tick permanent, so clamp them.
    assign w_period_sat = (period < PERIOD_W'(2)) ? PERIOD_W'(2) : period;
    assign w_tick       = en && (r_state != S_IDLE) && (r_tick_cnt == r_period - 1'b1);
    // A tick outside WAIT_TICK is dropped and flagged rather than queued.
    assign w_ovr_set    = w_tick && (r_state != S_WAIT_TICK);
    assign w_to_set     = en && (r_state == S_WAIT_DATA) && !adc.adc_valid
                          && (r_to_cnt == c_to_last);

    // Double-dabble correction: bump each digit >= 5 before the shift.
    for (genvar gi = 0; gi < 4; gi++) begin : g_dd_adj
        assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                      r_bcd[gi*4 +: 4] + 4'd3 : r_bcd[gi*4 +: 4];
    end

    // Tick counter: held at 0 (and period reloaded) while idle or disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_period   <= '0;
        end else if (!en || r_state == S_IDLE || w_tick) begin
            r_tick_cnt <= '0;
            r_period   <= w_period_sat;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Sequencer: request, accumulate, convert, publish; sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_to_cnt     <= '0;
            r_bin        <= '0;
            r_bcd        <= '0;
            r_iter       <= '0;
            r_digits     <= '0;
            r_adc_start  <= 1'b0;
            r_disp_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_adc_start  <= 1'b0;
            r_disp_valid <= 1'b0;
            r_overrun    <= w_ovr_set | (r_overrun & ~err_clr);
            r_timeout    <= w_to_set  | (r_timeout & ~err_clr);
            if (!en) begin
                r_state <= S_IDLE;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_WAIT_TICK;
                    S_WAIT_TICK: begin
                        if (w_tick) r_state <= S_START;
                    end
                    S_START: begin
                        if (!adc.adc_busy) begin
                            r_adc_start <= 1'b1;
                            r_to_cnt    <= '0;
                            r_state     <= S_WAIT_DATA;
                        end
                    end
                    S_WAIT_DATA: begin
                        if (adc.adc_valid) begin
                            r_acc <= r_acc + ACC_W'(adc.adc_data);
                            if (r_cnt == c_last_idx) begin
                                r_state <= S_LOAD;
                            end else begin
                                r_cnt   <= r_cnt + 1'b1;
                                r_state <= S_WAIT_TICK;
                            end
                        end else if (w_to_set) begin
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_state <= S_WAIT_TICK;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                    S_LOAD: begin
                        r_bin   <= 12'(r_acc >> AVG_LOG2);
                        r_bcd   <= '0;
                        r_iter  <= '0;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_BCD;
                    end
                    S_BCD: begin
                        {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                        r_iter         <= r_iter + 1'b1;
                        if (r_iter == 4'd11) r_state <= S_PUBLISH;
                    end
                    S_PUBLISH: begin
                        r_digits     <= r_bcd;
                        r_disp_valid <= 1'b1;
                        r_state      <= S_WAIT_TICK;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign adc.adc_start = r_adc_start;
    assign ones          = r_digits[3:0];
    assign tens          = r_digits[7:4];
    assign hundreds      = r_digits[11:8];
    assign thousands     = r_digits[15:12];
    assign disp_valid    = r_disp_valid;
    assign overrun       = r_overrun;
    assign timeout_err   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_sample_sched
//  Description : Self-checking bench for adc_sample_sched with an ADC
//                responder and a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_sample_sched;
    localparam int PERIOD_W = 24;
    localparam int AVG_LOG2 = 2;
    localparam int TIMEOUT  = 1024;
    localparam int N        = 1 << AVG_LOG2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en = 1'b0;
    logic                err_clr = 1'b0;
    logic [PERIOD_W-1:0] period = 24'd100;
    logic [3:0]          ones, tens, hundreds, thousands;
    logic                disp_valid, overrun, timeout_err;

    adc_sample_sched_if adc_if();

    adc_sample_sched #(.PERIOD_W(PERIOD_W), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .en(en), .period(period), .err_clr(err_clr),
        .adc(adc_if), .ones(ones), .tens(tens), .hundreds(hundreds),
        .thousands(thousands), .disp_valid(disp_valid), .overrun(overrun),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0, cyc = 0;
    bit chk_en = 0;
    int n_starts = 0, n_disp = 0, n_valid = 0, last_valid_cyc = 0;

    // responder controls
    bit          rsp_never = 0, rsp_rand = 0, rsp_pend = 0;
    int          rsp_lat = 10, rsp_left = 0;
    logic [11:0] rsp_const = 12'd1234;
    logic [11:0] samp_q[$];

    // model state: phase 0 idle, 1 waiting for tick, 2 want to start,
    // 3 awaiting data, 4 converting (countdown to publish)
    int m_phase = 0, m_cnt = 0, m_per = 2, m_wait = 0, m_crunch = 0;
    int m_pending = 0, m_val = 0;
    int m_samples[$];
    bit e_start = 0, e_disp = 0, e_ovr = 0, e_to = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic fail_wait(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: event not seen within bound (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [15:0] bcd_of(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [11:0] next_sample();
        if (samp_q.size() > 0) return samp_q.pop_front();
        if (rsp_rand) return 12'($urandom_range(4095, 0));
        return rsp_const;
    endfunction

    function automatic logic [15:0] dig();
        return {thousands, hundreds, tens, ones};
    endfunction

    task automatic model_step();
        bit tick, ovr_set, to_set, nstart, ndisp;
        int sum;
        cyc++;
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_per = 2; m_val = 0;
            m_samples.delete();
            e_ovr = 0; e_to = 0; e_start = 0; e_disp = 0;
            return;
        end
        ovr_set = 0; to_set = 0; nstart = 0; ndisp = 0;
        tick    = en && m_phase != 0 && m_cnt == m_per - 1;
        ovr_set = tick && m_phase != 1;
        if (!en || m_phase == 0 || tick) begin
            m_cnt = 0;
            m_per = (period < 2) ? 2 : int'(period);
        end else begin
            m_cnt++;
        end
        if (!en) begin
            m_phase = 0;
            m_samples.delete();
        end else begin
            case (m_phase)
                0: m_phase = 1;
                1: if (tick) m_phase = 2;
                2: if (!adc_if.adc_busy) begin nstart = 1; m_wait = 0; m_phase = 3; end
                3: begin
                    if (adc_if.adc_valid) begin
                        m_samples.push_back(int'(adc_if.adc_data));
                        if (m_samples.size() == N) begin
                            sum = 0;
                            foreach (m_samples[i]) sum += m_samples[i];
                            m_pending = sum / N;
                            m_samples.delete();
                            m_crunch = 13;
                            m_phase  = 4;
                        end else begin
                            m_phase = 1;
                        end
                    end else if (m_wait == TIMEOUT - 1) begin
                        to_set = 1;
                        m_samples.delete();
                        m_phase = 1;
                    end else begin
                        m_wait++;
                    end
                end
                4: begin
                    if (m_crunch == 0) begin m_val = m_pending; ndisp = 1; m_phase = 1; end
                    else m_crunch--;
                end
                default: ;
            endcase
        end
        e_ovr   = ovr_set | (e_ovr & !err_clr);
        e_to    = to_set  | (e_to  & !err_clr);
        e_start = nstart;
        e_disp  = ndisp;
    endtask

    // reference model advances on each active edge
    initial forever begin
        @(posedge clk);
        model_step();
    end

    // compare against the model, then play the ADC engine for the next cycle
    initial begin
        adc_if.adc_busy  = 1'b0;
        adc_if.adc_valid = 1'b0;
        adc_if.adc_data  = 12'd0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("adc_start",   32'(adc_if.adc_start), 32'(e_start));
                chk("disp_valid",  32'(disp_valid),       32'(e_disp));
                chk("digits",      32'(dig()),            32'(bcd_of(m_val)));
                chk("overrun",     32'(overrun),          32'(e_ovr));
                chk("timeout_err", 32'(timeout_err),      32'(e_to));
            end
            if (adc_if.adc_start) n_starts++;
            if (disp_valid) n_disp++;
            adc_if.adc_valid = 1'b0;
            if (rsp_pend) begin
                if (rsp_left == 0) begin
                    adc_if.adc_valid = 1'b1;
                    adc_if.adc_data  = next_sample();
                    adc_if.adc_busy  = 1'b0;
                    rsp_pend         = 0;
                    last_valid_cyc   = cyc;
                    n_valid++;
                end else begin
                    rsp_left--;
                end
            end
            if (adc_if.adc_start && !rsp_never) begin
                rsp_pend = 1;
                rsp_left = rsp_lat - 1;
                adc_if.adc_busy = 1'b1;
            end
        end
    end

    task automatic wait_sig(input int which, input int maxc, input string nm, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if ((which == 0 && adc_if.adc_start) || (which == 1 && disp_valid) ||
                (which == 2 && timeout_err)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) fail_wait(nm);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int s1, s2, d, t, k;
        // 1. reset
        repeat (3) @(negedge clk);
        chk("rst_digits", 32'(dig()), 32'h0);
        chk("rst_flags", 32'({disp_valid, overrun, timeout_err}), 32'h0);
        chk("rst_start", 32'(adc_if.adc_start), 32'h0);
        rst = 1'b0;
        chk_en = 1;
        k = n_starts;
        repeat (20) @(negedge clk);
        chk("idle_no_start", 32'(n_starts - k), 32'h0);

        // 2. constant 1234, period 100
        en = 1'b1; period = 24'd100; rsp_lat = 10; rsp_const = 12'd1234;
        wait_sig(0, 300, "first_start", s1);
        wait_sig(0, 300, "second_start", s2);
        chk("start_interval", 32'(s2 - s1), 32'd100);
        wait_sig(1, 600, "disp_1234", d);
        chk("disp_latency", 32'(d - last_valid_cyc), 32'd15);
        chk("digits_1234", 32'(dig()), 32'h1234);

        // 3. truncating average, then all zero
        samp_q = '{12'd4095, 12'd4095, 12'd4095, 12'd4094};
        wait_sig(1, 600, "disp_4094", d);
        chk("digits_4094", 32'(dig()), 32'h4094);
        samp_q = '{12'd0, 12'd0, 12'd0, 12'd0};
        wait_sig(1, 600, "disp_0", d);
        chk("digits_0", 32'(dig()), 32'h0);

        // 4. overrun with a short period and slow ADC
        period = 24'd5; rsp_lat = 20;
        repeat (200) @(negedge clk);
        chk("overrun_set", 32'(overrun), 32'h1);
        en = 1'b0;
        repeat (3) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        chk("overrun_clr", 32'(overrun), 32'h0);

        // 5. timeout, restart on next tick, then 4x1000
        en = 1'b1; period = 24'd100; rsp_never = 1; rsp_lat = 10; rsp_const = 12'd1000;
        wait_sig(0, 300, "to_start", s1);
        wait_sig(2, 1100, "timeout_flag", t);
        chk("timeout_at", 32'(t - s1), 32'd1024);
        rsp_never = 0;
        wait_sig(0, 200, "restart", s2);
        chk("restart_on_tick", 32'((s2 - s1) % 100), 32'h0);
        wait_sig(1, 600, "disp_1000", d);
        chk("digits_1000", 32'(dig()), 32'h1000);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        chk("timeout_clr", 32'(timeout_err), 32'h0);

        // 6. en dropped during conversion, then rst during WAIT_DATA
        rsp_const = 12'd2222;
        k = n_valid;
        for (int i = 0; i < 600 && n_valid < k + 4; i++) @(negedge clk);
        if (n_valid < k + 4) fail_wait("batch_2222");
        repeat (5) @(negedge clk);
        en = 1'b0;
        k = n_disp;
        repeat (30) @(negedge clk);
        chk("en_drop_digits", 32'(dig()), 32'h1000);
        chk("en_drop_no_disp", 32'(n_disp - k), 32'h0);
        en = 1'b1; rsp_lat = 50;
        wait_sig(0, 300, "rst_start", s1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_digits", 32'(dig()), 32'h0);
        chk("midrst_outs", 32'({adc_if.adc_start, disp_valid, overrun, timeout_err}), 32'h0);
        rst = 1'b0;

        // randomized run
        rsp_rand = 1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            en      = ($urandom_range(399, 0) != 0);
            err_clr = ($urandom_range(63, 0) == 0);
            rst     = ($urandom_range(1499, 0) == 0);
            if (i % 150 == 0) begin
                period  = 24'($urandom_range(120, 0));
                rsp_lat = $urandom_range(30, 1);
            end
        end
        rst = 1'b0; en = 1'b0; err_clr = 1'b0;
        repeat (5) @(negedge clk);
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
